// File: rtl/seu_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seu_pkg
// Purpose  : Shared types and constants for the SEU injection register bank.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package seu_pkg;

  // Injection controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } inj_state_t;

  // Upset mode encodings carried on INJ_MODE
  localparam logic INJ_TRANSIENT  = 1'b0;
  localparam logic INJ_PERSISTENT = 1'b1;

endpackage : seu_pkg
`default_nettype wire

// File: rtl/seu_inj_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seu_inj_ctrl
// Purpose  : Four-phase injection handshake FSM. Latches the target on request,
//            range-checks it, issues one-cycle flip strobes with one-hot
//            word/bit masks and keeps a saturating count of good injections.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module seu_inj_ctrl
  import seu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [BW-1:0]    bit_i,
  input  logic             mode_i,
  output logic             ack_o,
  output logic             err_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [DEPTH-1:0] word_mask_o,
  output logic [WIDTH-1:0] bit_mask_o,
  output logic             flip_persist_o,
  output logic             flip_transient_o
);

  inj_state_t       state_q, state_d;
  logic [AW-1:0]    addr_q;
  logic [BW-1:0]    bit_q;
  logic             mode_q;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0] word_mask;
  logic [WIDTH-1:0] bit_mask;
  logic             target_ok;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: APPLY is always a single cycle; DONE waits for req low
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i)  state_d = APPLY;
      APPLY:               state_d = DONE;
      DONE:    if (!req_i) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Output decode: one-hot masks from the latched target; an out-of-range
  // address or bit yields an all-zero mask, which doubles as the range check
  always_comb begin
    word_mask = '0;
    bit_mask  = '0;
    for (int w = 0; w < DEPTH; w++) begin
      word_mask[w] = (addr_q == AW'(w));
    end
    for (int b = 0; b < WIDTH; b++) begin
      bit_mask[b] = (bit_q == BW'(b));
    end
    target_ok        = (|word_mask) && (|bit_mask);
    flip_persist_o   = (state_q == APPLY) && target_ok && (mode_q == INJ_PERSISTENT);
    flip_transient_o = (state_q == APPLY) && target_ok && (mode_q == INJ_TRANSIENT);
  end

  assign word_mask_o = word_mask;
  assign bit_mask_o  = bit_mask;

  // Next values of the registered handshake outputs and the counter
  always_comb begin
    busy_d = (state_d != IDLE);
    ack_d  = (state_d == DONE);
    err_d  = (state_d == DONE) && !target_ok;
    cnt_d  = cnt_q;
    if ((state_q == APPLY) && target_ok && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Target latch (only on acceptance) and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      bit_q  <= '0;
      mode_q <= INJ_TRANSIENT;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if ((state_q == IDLE) && req_i) begin
        addr_q <= addr_i;
        bit_q  <= bit_i;
        mode_q <= mode_i;
      end
      ack_q  <= ack_d;
      err_q  <= err_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule : seu_inj_ctrl
`default_nettype wire

// File: rtl/seu_reg_bank.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seu_reg_bank
// Purpose  : DEPTH x WIDTH register bank with transient (read-view) and
//            persistent (stored-bit) single-event-upset injection.
//            Optional per-word even parity with mismatch flags is enabled by
//            defining SEU_PARITY_EN; otherwise PERR/PERR_STICKY read 0.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module seu_reg_bank
  import seu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    RADDR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QBAR,
  input  logic             INJ_REQ,
  input  logic [AW-1:0]    INJ_ADDR,
  input  logic [BW-1:0]    INJ_BIT,
  input  logic             INJ_MODE,
  output logic             INJ_ACK,
  output logic             INJ_ERR,
  output logic             INJ_BUSY,
  output logic [CNT_W-1:0] INJ_CNT,
  output logic             PERR,
  output logic             PERR_STICKY
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] word_mask;
  logic [WIDTH-1:0] bit_mask;
  logic             flip_persist;
  logic             flip_transient;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_tmask;
  logic [WIDTH-1:0] q_w;

  seu_inj_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .AW    (AW),
    .BW    (BW)
  ) u_ctrl (
    .clk_i            (CLK),
    .rst_i            (RST),
    .req_i            (INJ_REQ),
    .addr_i           (INJ_ADDR),
    .bit_i            (INJ_BIT),
    .mode_i           (INJ_MODE),
    .ack_o            (INJ_ACK),
    .err_o            (INJ_ERR),
    .busy_o           (INJ_BUSY),
    .cnt_o            (INJ_CNT),
    .word_mask_o      (word_mask),
    .bit_mask_o       (bit_mask),
    .flip_persist_o   (flip_persist),
    .flip_transient_o (flip_transient)
  );

  // Storage next state: write first, then a persistent flip on top, so a
  // same-cycle write lands as D with the target bit inverted
  always_comb begin
    for (int w = 0; w < DEPTH; w++) begin
      mem_d[w] = mem_q[w];
      if (WE && (WADDR == AW'(w))) begin
        mem_d[w] = D;
      end
      if (flip_persist && word_mask[w]) begin
        mem_d[w] = mem_d[w] ^ bit_mask;
      end
    end
  end

  // Storage array
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= mem_d[w];
      end
    end
  end

  // Combinational read with the transient mask overlaid on the targeted word;
  // an out-of-range RADDR reads as zero
  always_comb begin
    rd_word  = '0;
    rd_tmask = '0;
    for (int w = 0; w < DEPTH; w++) begin
      if (RADDR == AW'(w)) begin
        rd_word = mem_q[w];
        if (flip_transient && word_mask[w]) begin
          rd_tmask = bit_mask;
        end
      end
    end
    q_w = rd_word ^ rd_tmask;
  end

  assign Q    = q_w;
  assign QBAR = ~q_w;

`ifdef SEU_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
  logic             rd_par;
  logic             perr_w;
  logic             sticky_q, sticky_d;

  // Parity tracks writes only, so any injected flip shows up as a mismatch
  always_comb begin
    for (int w = 0; w < DEPTH; w++) begin
      par_d[w] = par_q[w];
      if (WE && (WADDR == AW'(w))) begin
        par_d[w] = ^D;
      end
    end
  end

  // Parity check against the word currently being read
  always_comb begin
    rd_par = 1'b0;
    for (int w = 0; w < DEPTH; w++) begin
      if (RADDR == AW'(w)) begin
        rd_par = par_q[w];
      end
    end
    perr_w   = (^q_w) != rd_par;
    sticky_d = sticky_q | perr_w;
  end

  // Parity store and sticky error flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      par_q    <= par_d;
      sticky_q <= sticky_d;
    end
  end

  assign PERR        = perr_w;
  assign PERR_STICKY = sticky_q;
`else
  assign PERR        = 1'b0;
  assign PERR_STICKY = 1'b0;
`endif

endmodule : seu_reg_bank
`default_nettype wire
